// File: rtl/instruction_sender.sv
// Byte-serial GPU instruction bus transmitter: sends the opcode byte, then 0..3
// argument bytes MSB-first, pacing every strobe on the receiver's i_ack handshake.
module instruction_sender #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_instruction,
  input  logic [1:0]  i_nargs,
  input  logic        i_ack,
  output logic        o_we,
  output logic        o_en,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned SETUP_N = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int SCW = (SETUP_N < 2) ? 1 : $clog2(SETUP_N);
  localparam int WCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_N - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, GAP} state_t;

  state_t         state_q;
  logic           we_q;
  logic           en_q;
  logic [7:0]     data_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic [31:0]    instr_q;
  logic [1:0]     rem_q;
  logic [SCW-1:0] setup_q;
  logic [WCW-1:0] wait_q;

  logic [7:0] next_byte;
  logic       wait_expired;

  // rem_q counts down, so it doubles as the index of the next argument byte
  assign next_byte    = instr_q[{rem_q, 3'b000} +: 8];
  assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      we_q    <= 1'b1;
      en_q    <= 1'b1;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      instr_q <= '0;
      rem_q   <= '0;
      setup_q <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          if (i_start) begin
            instr_q <= i_instruction;
            rem_q   <= i_nargs;
            data_q  <= i_instruction[7:0];
            we_q    <= 1'b0;
            busy_q  <= 1'b1;
            setup_q <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (setup_q == SETUP_LAST) begin
            en_q    <= 1'b0;
            wait_q  <= '0;
            state_q <= STROBE;
          end else begin
            setup_q <= setup_q + SCW'(1);
          end
        end
        STROBE: begin
          if (i_ack) begin
            en_q    <= 1'b1;
            wait_q  <= '0;
            state_q <= RELEASE;
          end else if (wait_expired) begin
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        RELEASE: begin
          if (!i_ack) begin
            if (rem_q != 2'd0) begin
              data_q  <= next_byte;
              rem_q   <= rem_q - 2'd1;
              state_q <= GAP;
            end else begin
              we_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (wait_expired) begin
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        GAP: begin
          en_q    <= 1'b0;
          wait_q  <= '0;
          state_q <= STROBE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_we    = we_q;
  assign o_en    = en_q;
  assign o_data  = data_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_instruction_sender.sv
// Bench for instruction_sender: cycle-level bus model plus a receiver-side
// scoreboard, driven by directed frames and randomized transactions.
`timescale 1ns/1ps
module tb_instruction_sender;
  localparam int SU = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [1:0]  nargs = 2'd0;
  logic        ack = 1'b0;
  logic        we, en, busy, done, err;
  logic [7:0]  data;

  instruction_sender #(.SETUP_CYCLES(SU), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_instruction(instr),
    .i_nargs(nargs), .i_ack(ack), .o_we(we), .o_en(en), .o_data(data),
    .o_busy(busy), .o_done(done), .o_error(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Bus model: phases of a frame as seen on the wire
  typedef enum {M_IDLE, M_SETUP, M_LOW, M_HIGH, M_GAP} mph_t;
  mph_t        mph = M_IDLE;
  int          m_cnt = 0, m_nb = 0, m_idx = 0;
  logic [7:0]  m_bytes[4];
  logic        e_we = 1'b1, e_en = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [7:0]  e_data = 8'h00;
  bit          mvalid = 1'b0;
  logic [31:0] sb_word = 32'h0;
  int          sb_n = 0;

  task automatic model_abort();
    e_en = 1'b1; e_we = 1'b1; e_err = 1'b1; e_busy = 1'b0; mph = M_IDLE;
  endtask

  task automatic model_step();
    int n;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (reset) begin
      mph = M_IDLE; e_we = 1'b1; e_en = 1'b1; e_data = 8'h00; e_busy = 1'b0;
    end else begin
      case (mph)
        M_IDLE: if (start) begin
          n = int'(nargs);
          m_nb = n + 1;
          m_bytes[0] = instr[7:0];
          for (int j = 1; j < m_nb; j++) m_bytes[j] = 8'((instr >> (8 * (m_nb - j))) & 32'hFF);
          sb_n = n;
          sb_word = instr & ((n == 3) ? 32'hFFFF_FFFF : ((32'd1 << (8 * (n + 1))) - 32'd1));
          m_idx = 1; e_data = m_bytes[0]; e_we = 1'b0; e_busy = 1'b1; m_cnt = 1; mph = M_SETUP;
        end
        M_SETUP: if (m_cnt >= SU) begin
          e_en = 1'b0; m_cnt = 0; mph = M_LOW;
        end else m_cnt++;
        M_LOW: if (ack) begin
          e_en = 1'b1; m_cnt = 0; mph = M_HIGH;
        end else begin
          m_cnt++;
          if (TO != 0 && m_cnt >= TO) model_abort();
        end
        M_HIGH: if (!ack) begin
          if (m_idx < m_nb) begin
            e_data = m_bytes[m_idx]; m_idx++; mph = M_GAP;
          end else begin
            e_we = 1'b1; e_busy = 1'b0; e_done = 1'b1; mph = M_IDLE;
          end
        end else begin
          m_cnt++;
          if (TO != 0 && m_cnt >= TO) model_abort();
        end
        M_GAP: begin
          e_en = 1'b0; m_cnt = 0; mph = M_LOW;
        end
        default: mph = M_IDLE;
      endcase
    end
  endtask

  // Receiver-side monitor state
  logic [7:0]  rx[4];
  logic [7:0]  last_bytes[4];
  logic [31:0] last_word = 32'h0;
  int rx_n = 0, last_n = 0, setup_run = 0, last_setup = 0;
  int en_low_run = 0, last_low_run = 0, we_high_run = 0, last_gap = 0;
  int done_cnt = 0, err_cnt = 0, fall_total = 0;
  logic prev_we = 1'b1, prev_en = 1'b1;

  always @(negedge clk) begin
    logic [31:0] w;
    if (mvalid) begin
      checks++;
      if ({we, en, busy, done, err, data} !== {e_we, e_en, e_busy, e_done, e_err, e_data}) begin
        errors++;
        $display("FAIL bus_cycle at %0t: we,en,busy,done,err/data got %b%b%b%b%b/%h expected %b%b%b%b%b/%h",
                 $time, we, en, busy, done, err, data, e_we, e_en, e_busy, e_done, e_err, e_data);
      end
    end
    if (reset) rx_n = 0;
    if (prev_we && !we) begin
      rx_n = 0; setup_run = 0; last_gap = we_high_run;
    end
    if (we) we_high_run++; else we_high_run = 0;
    if (!we && en && rx_n == 0 && busy) setup_run++;
    if (prev_en && !en) begin
      if (rx_n == 0) last_setup = setup_run;
      if (rx_n < 4) rx[rx_n] = data;
      rx_n++; fall_total++; en_low_run = 0;
    end
    if (!en) en_low_run++;
    if (!prev_en && en) last_low_run = en_low_run;
    if (done) begin
      w = {24'h0, rx[0]};
      for (int j = 1; j < rx_n && j < 4; j++) w[31:8] = {w[23:8], rx[j]};
      chk("rx_word", w, sb_word);
      chk("strobe_count", 32'(rx_n), 32'(sb_n + 1));
      last_word = w; last_n = rx_n;
      for (int j = 0; j < 4; j++) last_bytes[j] = rx[j];
      done_cnt++;
    end
    if (err) err_cnt++;
    prev_we = we; prev_en = en;
    model_step();
    mvalid = 1'b1;
  end

  // Responder: 0 never acks, 1 delayed handshake, 2 ack stuck high, 3 random noise
  int resp_mode = 0, rise_d = 1, fall_d = 1, lo_cnt = 0, hi_cnt = 0;

  task automatic tick();
    @(posedge clk); #2;
    case (resp_mode)
      0: ack = 1'b0;
      2: ack = busy && (ack || !en);
      3: ack = 1'($urandom_range(0, 1));
      default: begin
        if (!en) begin
          hi_cnt = 0;
          if (lo_cnt >= rise_d) ack = 1'b1;
          lo_cnt++;
        end else begin
          lo_cnt = 0;
          if (ack && hi_cnt >= fall_d) ack = 1'b0;
          hi_cnt++;
        end
      end
    endcase
  endtask

  task automatic send(input logic [31:0] w, input logic [1:0] n);
    instr = w; nargs = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 400) begin tick(); k++; end
    chk(name, 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    int d0, e0, base, k, hi, started, dn;
    reset = 1'b1; resp_mode = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_state", 32'({we, en, busy, done, err, data}), 32'({5'b11000, 8'h00}));
    base = fall_total; resp_mode = 3;
    repeat (10) tick();
    resp_mode = 1; ack = 1'b0;
    tick();
    chk("idle_no_strobe", 32'(fall_total - base), 32'd0);
    chk("idle_we_high", 32'(we), 32'd1);

    rise_d = 1; fall_d = 1; d0 = done_cnt;
    send(32'hAABBCC05, 2'd3);
    wait_idle("frameA_end");
    chk("A_word", last_word, 32'hAABBCC05);
    chk("A_b0", 32'(last_bytes[0]), 32'h05);
    chk("A_b1", 32'(last_bytes[1]), 32'hAA);
    chk("A_b2", 32'(last_bytes[2]), 32'hBB);
    chk("A_b3", 32'(last_bytes[3]), 32'hCC);
    chk("A_setup", 32'(last_setup), 32'd2);
    chk("A_done", 32'(done_cnt - d0), 32'd1);

    send(32'h12345611, 2'd0);
    wait_idle("frameB_end");
    chk("B_nstrobe", 32'(last_n), 32'd1);
    chk("B_b0", 32'(last_bytes[0]), 32'h11);
    send(32'h99887E11, 2'd1);
    wait_idle("frameC_end");
    chk("C_word", last_word, 32'h00007E11);
    chk("C_nstrobe", 32'(last_n), 32'd2);
    chk("C_b1", 32'(last_bytes[1]), 32'h7E);

    resp_mode = 0; e0 = err_cnt; d0 = done_cnt;
    send(32'hDEADBE42, 2'd2);
    wait_idle("timeout_end");
    chk("to_low_run", 32'(last_low_run), 32'd8);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_no_done", 32'(done_cnt - d0), 32'd0);

    resp_mode = 1; rise_d = 4; fall_d = 0;
    send(32'h33221100, 2'd3);
    k = 0;
    while (!(en == 1'b0 && data == 8'h22) && k < 200) begin tick(); k++; end
    chk("rst_reach_arg2", 32'(k < 200), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid", 32'({we, en, busy, done, err}), 32'({5'b11000}));
    tick();
    send(32'h0BADF00D, 2'd3);
    wait_idle("post_rst_end");
    chk("post_rst_word", last_word, 32'h0BADF00D);

    rise_d = 0; fall_d = 0; d0 = done_cnt;
    instr = 32'h01020304; nargs = 2'd2; start = 1'b1;
    hi = 0; started = 0; dn = 0; k = 0;
    while (dn < 3 && k < 300) begin
      tick(); k++;
      if (done) dn++;
      if (we) hi++;
      else if (hi > 0) begin
        if (started > 0) chk("b2b_gap", 32'(hi), 32'd1);
        started++; hi = 0;
      end
      if (dn < 3) instr = $urandom;
    end
    start = 1'b0;
    chk("b2b_frames", 32'(dn), 32'd3);
    wait_idle("b2b_end");

    repeat (40) begin
      rise_d = $urandom_range(0, 4); fall_d = $urandom_range(0, 4);
      k = $urandom_range(0, 11);
      resp_mode = (k == 0) ? 2 : ((k == 1) ? 0 : 1);
      send($urandom, 2'($urandom_range(0, 3)));
      k = 0;
      while (busy && k < 400) begin
        if ($urandom_range(0, 3) == 0) instr = $urandom;
        nargs = 2'($urandom_range(0, 3));
        start = ($urandom_range(0, 4) == 0);
        tick(); k++;
      end
      start = 1'b0;
      chk("rand_frame_end", 32'(busy), 32'd0);
      repeat ($urandom_range(1, 3)) tick();
    end
    resp_mode = 1;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
